aom_dac_arbiter: RTL and testbench

AOM_DAC_ARBITER -- requirements
Module: aom_dac_arbiter

---
 rtl/laser_aom_pkg.sv | 35 +++
 rtl/aom_dac_arbiter_if.sv | 28 ++
 rtl/aom_req_slot.sv | 47 ++++
 rtl/aom_dac_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_aom_dac_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/laser_aom_pkg.sv
// Shared types for the AOM DAC arbiter: FSM encoding, source IDs, voltage width.
// Also holds the capture clamp used by every requester slot.
package laser_aom_pkg;

    localparam int VOL_W = 12;

    typedef logic [VOL_W-1:0] vol_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_SAFE  = 2'd1;
    localparam logic [1:0] SRC_ACC   = 2'd2;
    localparam logic [1:0] SRC_LASER = 2'd3;

    // An inverted window collapses onto the upper limit.
    function automatic vol_t clamp_vol(input vol_t vol, input vol_t up, input vol_t low);
        vol_t res;
        if (low > up) begin
            res = up;
        end else if (vol > up) begin
            res = up;
        end else if (vol < low) begin
            res = low;
        end else begin
            res = vol;
        end
        return res;
    endfunction

endpackage

// File: rtl/aom_dac_arbiter_if.sv
// DAC write channel bundle: valid/ready handshake plus the granted source and
// last accepted voltage; master is the arbiter, slave is the DAC side.
interface aom_dac_arbiter_if;
    import laser_aom_pkg::*;

    logic       valid;
    logic       ready;
    vol_t       data;
    logic [1:0] src;
    vol_t       cur_vol;

    modport master (
        output valid,
        output data,
        output src,
        output cur_vol,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  src,
        input  cur_vol,
        output ready
    );

endinterface

// File: rtl/aom_req_slot.sv
// One pending-request slot: clamps and captures on en, cleared by a grant; 1-cycle capture.
// No backpressure: a new en overwrites a waiting value and flags the overwrite.
module aom_req_slot
    import laser_aom_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  vol_t vol_i,
    input  vol_t up_i,
    input  vol_t low_i,
    input  logic clr_i,
    output logic pend_o,
    output vol_t val_o,
    output logic ovf_o
);

    logic pend_q, pend_d;
    vol_t val_q,  val_d;

    // A capture in the same cycle as the grant refills the slot without counting a drop.
    always_comb begin
        pend_d = pend_q;
        val_d  = val_q;
        if (en_i) begin
            pend_d = 1'b1;
            val_d  = clamp_vol(vol_i, up_i, low_i);
        end else if (clr_i) begin
            pend_d = 1'b0;
        end
    end

    assign ovf_o  = en_i & pend_q & ~clr_i;
    assign pend_o = pend_q;
    assign val_o  = val_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q <= 1'b0;
            val_q  <= '0;
        end else begin
            pend_q <= pend_d;
            val_q  <= val_d;
        end
    end

endmodule

// File: rtl/aom_dac_arbiter.sv
// Fixed-priority DAC arbiter (safety > acc > laser) with safety lock and post-write settle gap.
// en-to-valid 2 cycles from idle; valid/data held until dac_ready_i, then SETTLE_CYCLES idle.
module aom_dac_arbiter
    import laser_aom_pkg::*;
#(
    parameter real TCQ           = 0.1,
    parameter int  SETTLE_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        safe_en_i,
    input  vol_t        safe_vol_i,
    input  logic        safe_release_i,
    input  logic        acc_en_i,
    input  vol_t        acc_vol_i,
    input  logic        laser_en_i,
    input  vol_t        laser_vol_i,
    input  vol_t        uplimit_i,
    input  vol_t        lowlimit_i,
    output logic        dac_valid_o,
    output vol_t        dac_data_o,
    input  logic        dac_ready_i,
    output logic [1:0]  dac_src_o,
    output vol_t        cur_vol_o,
    output logic        lock_o,
    output logic [15:0] drop_cnt_o
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || TCQ < 0.0) begin : g_bad_param
        $error("aom_dac_arbiter: parameter out of range");
    end

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    // Slot index 0 = safety, 1 = acc, 2 = laser; index order is priority order.
    logic [2:0] req_en;
    vol_t       req_vol [3];
    logic [2:0] pend;
    vol_t       pend_val [3];
    logic [2:0] ovf;
    logic [2:0] clr;

    assign req_en     = {laser_en_i, acc_en_i, safe_en_i};
    assign req_vol[0] = safe_vol_i;
    assign req_vol[1] = acc_vol_i;
    assign req_vol[2] = laser_vol_i;

    for (genvar i = 0; i < 3; i++) begin : g_slot
        aom_req_slot u_slot (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .en_i    (req_en[i]),
            .vol_i   (req_vol[i]),
            .up_i    (uplimit_i),
            .low_i   (lowlimit_i),
            .clr_i   (clr[i]),
            .pend_o  (pend[i]),
            .val_o   (pend_val[i]),
            .ovf_o   (ovf[i])
        );
    end

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    vol_t        data_q,  data_d;
    logic [1:0]  src_q,   src_d;
    vol_t        cur_q,   cur_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic        lock_q,  lock_d;
    logic [15:0] drop_q,  drop_d;

    logic [2:0]  eligible;
    logic [1:0]  ovf_sum;
    logic [16:0] drop_sum;

    // Locked: acc and laser keep capturing but are invisible to the arbiter.
    assign eligible = {pend[2] & ~lock_q, pend[1] & ~lock_q, pend[0]};

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        clr     = 3'b000;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                src_d   = SRC_NONE;
                if (eligible[0]) begin
                    clr[0]  = 1'b1;
                    data_d  = pend_val[0];
                    src_d   = SRC_SAFE;
                    valid_d = 1'b1;
                    state_d = ST_WRITE;
                end else if (eligible[1]) begin
                    clr[1]  = 1'b1;
                    data_d  = pend_val[1];
                    src_d   = SRC_ACC;
                    valid_d = 1'b1;
                    state_d = ST_WRITE;
                end else if (eligible[2]) begin
                    clr[2]  = 1'b1;
                    data_d  = pend_val[2];
                    src_d   = SRC_LASER;
                    valid_d = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (valid_q && dac_ready_i) begin
                    cur_d   = data_q;
                    valid_d = 1'b0;
                    src_d   = SRC_NONE;
                    cnt_d   = SETTLE_LAST;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                src_d = SRC_NONE;
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                src_d   = SRC_NONE;
            end
        endcase
    end

    // Lock release looks at the registered safety slot, so a waiting safety write keeps it set.
    always_comb begin
        lock_d = lock_q;
        if (safe_en_i) begin
            lock_d = 1'b1;
        end else if (safe_release_i && !pend[0]) begin
            lock_d = 1'b0;
        end
    end

    always_comb begin
        ovf_sum  = 2'(ovf[0]) + 2'(ovf[1]) + 2'(ovf[2]);
        drop_sum = {1'b0, drop_q} + {15'd0, ovf_sum};
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= SRC_NONE;
            cur_q   <= '0;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            drop_q  <= drop_d;
        end
    end

    assign dac_valid_o = valid_q;
    assign dac_data_o  = data_q;
    assign dac_src_o   = src_q;
    assign cur_vol_o   = cur_q;
    assign lock_o      = lock_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_aom_dac_arbiter.sv
// Bench for aom_dac_arbiter: clamp table, directed corner sequences, random traffic
// checked every cycle against a timestamp-based model of the arbitration rules.
module tb_aom_dac_arbiter;
    import laser_aom_pkg::*;

    localparam int SETTLE = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        safe_en = 1'b0, safe_rel = 1'b0, acc_en = 1'b0, laser_en = 1'b0;
    logic [11:0] safe_vol = '0, acc_vol = '0, laser_vol = '0;
    logic [11:0] up = 12'hFFF, low = 12'h000;
    logic        lock;
    logic [15:0] drop;

    aom_dac_arbiter_if dac_if ();

    always #5 clk = ~clk;

    aom_dac_arbiter #(.TCQ(0.1), .SETTLE_CYCLES(SETTLE)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .safe_en_i      (safe_en),
        .safe_vol_i     (safe_vol),
        .safe_release_i (safe_rel),
        .acc_en_i       (acc_en),
        .acc_vol_i      (acc_vol),
        .laser_en_i     (laser_en),
        .laser_vol_i    (laser_vol),
        .uplimit_i      (up),
        .lowlimit_i     (low),
        .dac_valid_o    (dac_if.valid),
        .dac_data_o     (dac_if.data),
        .dac_ready_i    (dac_if.ready),
        .dac_src_o      (dac_if.src),
        .cur_vol_o      (dac_if.cur_vol),
        .lock_o         (lock),
        .drop_cnt_o     (drop)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: slots as arrays, settle gap as an "earliest next grant" edge index.
    int          cyc = 0;
    int          idle_at = 0;
    bit          pend [3];
    logic [11:0] pval [3];
    logic        m_valid, m_lock;
    logic [11:0] m_data, m_cur;
    logic [1:0]  m_src;
    int          m_drop;

    function automatic logic [11:0] ref_clamp(logic [11:0] v, logic [11:0] u, logic [11:0] l);
        if (l > u) return u;
        return (v > u) ? u : ((v < l) ? l : v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            pend[i] = 0;
            pval[i] = '0;
        end
        m_valid = 0; m_lock = 0; m_data = '0; m_cur = '0; m_src = 2'd0; m_drop = 0;
        idle_at = 0;
    endtask

    task automatic model_edge();
        int          g;
        bit          en [3];
        logic [11:0] v [3];
        bit          lock_n;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        en[0] = safe_en; en[1] = acc_en; en[2] = laser_en;
        v[0]  = safe_vol; v[1] = acc_vol; v[2] = laser_vol;
        g = -1;
        if (m_valid) begin
            if (dac_if.ready) begin
                m_cur   = m_data;
                m_valid = 0;
                m_src   = 2'd0;
                idle_at = cyc + SETTLE + 1;
            end
        end else if (cyc >= idle_at) begin
            for (int i = 0; i < 3; i++)
                if (g < 0 && pend[i] && (i == 0 || !m_lock)) g = i;
            if (g >= 0) begin
                m_valid = 1;
                m_data  = pval[g];
                m_src   = 2'(g + 1);
            end
        end
        lock_n = m_lock;
        if (safe_en) lock_n = 1;
        else if (safe_rel && !pend[0]) lock_n = 0;
        m_lock = lock_n;
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                if (pend[i] && g != i && m_drop < 16'hFFFF) m_drop++;
                pend[i] = 1;
                pval[i] = ref_clamp(v[i], up, low);
            end else if (g == i) begin
                pend[i] = 0;
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        safe_en = 0; acc_en = 0; laser_en = 0; safe_rel = 0;
        check("valid",  32'(dac_if.valid),   32'(m_valid));
        check("data",   32'(dac_if.data),    32'(m_data));
        check("src",    32'(dac_if.src),     32'(m_src));
        check("curvol", 32'(dac_if.cur_vol), 32'(m_cur));
        check("lock",   32'(lock),           32'(m_lock));
        check("drop",   32'(drop),           32'(m_drop));
    endtask

    task automatic fire(int sel, logic [11:0] v);
        case (sel)
            0: begin safe_en = 1; safe_vol = v; end
            1: begin acc_en = 1; acc_vol = v; end
            default: begin laser_en = 1; laser_vol = v; end
        endcase
    endtask

    task automatic wait_valid(string name, int budget);
        bit ok = 0;
        for (int k = 0; k < budget; k++) begin
            if (dac_if.valid) begin
                ok = 1;
                break;
            end
            step();
        end
        check(name, 32'(ok), 32'd1);
    endtask

    typedef struct {
        int          sel;
        logic [11:0] vol;
        logic [11:0] up;
        logic [11:0] low;
        logic [11:0] exp;
    } clamp_vec_t;

    clamp_vec_t tbl [8];

    initial begin
        int n;
        int bad;
        int d0;
        bit seen;

        tbl[0] = '{2, 12'h800, 12'hE00, 12'h100, 12'h800};
        tbl[1] = '{1, 12'hF00, 12'hE00, 12'h100, 12'hE00};
        tbl[2] = '{2, 12'h050, 12'hE00, 12'h100, 12'h100};
        tbl[3] = '{1, 12'h123, 12'h400, 12'h900, 12'h400};
        tbl[4] = '{2, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF};
        tbl[5] = '{1, 12'h000, 12'hFFF, 12'h000, 12'h000};
        tbl[6] = '{2, 12'h100, 12'hE00, 12'h100, 12'h100};
        tbl[7] = '{1, 12'hE00, 12'hE00, 12'h100, 12'hE00};

        dac_if.ready = 1;
        model_reset();
        repeat (3) step();
        check("rst_valid", 32'(dac_if.valid), 32'd0);
        check("rst_src",   32'(dac_if.src),   32'd0);
        rst_n = 1;
        step();

        // Single write: latency and settle gap.
        up = 12'hE00; low = 12'h100;
        fire(2, 12'h800);
        step();
        check("lat_n1_valid", 32'(dac_if.valid), 32'd0);
        step();
        check("lat_n2_valid", 32'(dac_if.valid), 32'd1);
        check("lat_n2_data",  32'(dac_if.data),  32'h800);
        check("lat_n2_src",   32'(dac_if.src),   32'd3);
        step();
        check("single_cur",   32'(dac_if.cur_vol), 32'h800);
        fire(2, 12'h200);
        n = 0;
        do begin
            step();
            n++;
        end while (!dac_if.valid && n < 60);
        check("settle_gap", 32'(n), 32'(SETTLE + 1));
        repeat (SETTLE + 4) step();

        // Clamp table.
        foreach (tbl[i]) begin
            up = tbl[i].up; low = tbl[i].low;
            fire(tbl[i].sel, tbl[i].vol);
            step();
            wait_valid("clamp_wait", 10);
            check("clamp_data", 32'(dac_if.data), 32'(tbl[i].exp));
            check("clamp_src",  32'(dac_if.src),  32'(tbl[i].sel + 1));
            repeat (SETTLE + 4) step();
        end

        // Priority and lock.
        up = 12'hFFF; low = 12'h000;
        fire(0, 12'h000); fire(1, 12'h123); fire(2, 12'h456);
        step();
        wait_valid("prio_wait_safe", 10);
        check("prio_safe_src", 32'(dac_if.src), 32'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (dac_if.valid) seen = 1;
        end
        check("lock_held",  32'(lock), 32'd1);
        check("lock_nogrant", 32'(seen), 32'd0);
        safe_rel = 1;
        step();
        wait_valid("prio_wait_acc", 10);
        check("prio_acc_src",  32'(dac_if.src),  32'd2);
        check("prio_acc_data", 32'(dac_if.data), 32'h123);
        step();
        wait_valid("prio_wait_laser", 40);
        check("prio_laser_src",  32'(dac_if.src),  32'd3);
        check("prio_laser_data", 32'(dac_if.data), 32'h456);
        check("lock_cleared",    32'(lock),        32'd0);
        repeat (SETTLE + 4) step();

        // Backpressure with laser overwrites.
        dac_if.ready = 0;
        fire(1, 12'h700);
        step();
        wait_valid("bp_wait", 10);
        d0 = int'(drop);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 5)  fire(2, 12'h300);
            if (k == 10) fire(2, 12'h400);
            if (k == 15) fire(2, 12'h500);
            step();
            if (!dac_if.valid || dac_if.data != 12'h700 || dac_if.src != 2'd2) bad++;
        end
        check("bp_stable", 32'(bad), 32'd0);
        check("bp_drops",  32'(drop), 32'(d0 + 2));
        dac_if.ready = 1;
        step();
        wait_valid("bp_wait_laser", 40);
        check("bp_laser_data", 32'(dac_if.data), 32'h500);
        repeat (SETTLE + 4) step();

        // Reset in the middle of a write.
        dac_if.ready = 0;
        fire(1, 12'h555);
        step();
        wait_valid("rst_wait", 10);
        rst_n = 0;
        #1;
        check("rstw_valid", 32'(dac_if.valid),   32'd0);
        check("rstw_data",  32'(dac_if.data),    32'd0);
        check("rstw_src",   32'(dac_if.src),     32'd0);
        check("rstw_cur",   32'(dac_if.cur_vol), 32'd0);
        check("rstw_drop",  32'(drop),           32'd0);
        check("rstw_lock",  32'(lock),           32'd0);
        repeat (3) step();
        rst_n = 1;
        dac_if.ready = 1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (dac_if.valid) seen = 1;
        end
        check("rstw_nowrite", 32'(seen), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            if (k % 200 == 0) begin
                up  = 12'($urandom);
                low = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 32'(up)));
            end
            dac_if.ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) fire(0, 12'($urandom));
            if ($urandom_range(0, 7) == 0)  fire(1, 12'($urandom));
            if ($urandom_range(0, 5) == 0)  fire(2, 12'($urandom));
            safe_rel = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
